accel_run_driver: RTL and testbench
===================================

Name: accel_run_driver

Overview:
- Parametrised driver that launches the accelerator NUM_RUNS times back-to-back.
- For each run: issues a one-cycle start pulse, waits for done, and measures latency in cycles.
- Keeps last/min/max/total latency statistics.
- Detects hung runs with a timeout.
- Sits between the top-level test harness and the accelerator top; replaces the single-shot start/wait driver.

Parameters:
- NUM_RUNS, 4, runs per session (>=1).
- CNT_W, 64, width of latency and statistics counters.
- TIMEOUT_CYCLES, 1000000, per-run cycle limit; 0 disables the timeout.
- GAP_CYCLES, 2, idle cycles between a done and the next start (0 allowed).
- RUN_W, $clog2(NUM_RUNS+1), width of the run counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  level; high requests a session
- acc_done  in  1  accelerator done; sampled only in WAIT
- acc_start  out  1  one-cycle start pulse to the accelerator
- busy  out  1  high in START/WAIT/GAP
- all_done  out  1  high in FINISH
- timed_out  out  1  sticky per session; set on timeout
- run_count  out  RUN_W  completed runs this session
- stat_valid  out  1  one-cycle pulse when a run's statistics update
- last_cycles  out  CNT_W  latency of most recent run
- min_cycles  out  CNT_W  minimum latency this session
- max_cycles  out  CNT_W  maximum latency this session
- total_cycles  out  CNT_W  saturating sum of latencies

Behaviour:
- Reset values:
  - state=IDLE.
  - acc_start, busy, all_done, timed_out, stat_valid = 0.
  - run_count=0; last, max, total = 0; min = all ones.
  - rst has priority in every state, including mid-run. acc_start drops on the next edge; no done is awaited.
- States and transitions:
  - IDLE: enable=1 -> START. Entering START from IDLE clears the statistics, run_count and timed_out to their reset values.
  - START: acc_start=1 for exactly this cycle. Latency counter loads 1. Always -> WAIT next cycle. acc_done in START is ignored.
  - WAIT: latency counter increments each cycle it remains in WAIT (saturates at all ones).
    - If acc_done=1 -> record the run (rules below) and pulse stat_valid in the next cycle.
    - Then: if run_count+1==NUM_RUNS -> FINISH; else if GAP_CYCLES==0 -> START; else GAP.
  - Timeout: if acc_done=0, TIMEOUT_CYCLES!=0 and latency==TIMEOUT_CYCLES -> timed_out<=1, no statistics update, -> FINISH. Done and timeout in the same cycle: done wins.
  - GAP: stays GAP_CYCLES cycles, then -> START.
  - FINISH: all_done=1. Holds until enable=0 -> IDLE. Statistics remain readable in IDLE until the next session starts.
- Dropping enable during START/WAIT/GAP does not abort. The current session completes to FINISH, then exits immediately if enable is still 0.
- Latency definition: the count of cycles from the acc_start cycle to the acc_done cycle, inclusive of the done cycle and exclusive of the start cycle. Done on the cycle right after start = 1.
- Recording a run (all updated on the same edge):
  - last <= latency
  - min <= min(min, latency)
  - max <= max(max, latency)
  - total <= total+latency, saturating at 2^CNT_W-1
  - run_count++
- stat_valid is registered: high in the cycle after the update edge.

Decomposition:
- Shared package accel_drv_pkg holds:
  - state enum (IDLE, START, WAIT, GAP, FINISH), 3-bit
  - saturating-add function
  - CNT_W default constant
- One sub-module: sat_counter (parametrised width; load, increment, saturate). Used for the latency counter and the gap counter.

Test Plan:
- NUM_RUNS=3, GAP=2; done at 5, 9, 7 cycles after each start -> last=7, min=5, max=9, total=21, run_count=3, three stat_valid pulses; all_done stays high while enable=1.
- acc_done held high through START -> ignored in START; first WAIT cycle sees done -> latency=1.
- TIMEOUT_CYCLES=20, no done -> timed_out=1 after exactly 20 WAIT-count cycles; statistics unchanged; state FINISH; run_count=0.
- Done and timeout on the same cycle (done at 20, TIMEOUT=20) -> run recorded with latency 20; timed_out=0.
- rst asserted in WAIT of run 2 -> next cycle all outputs at reset values; a new session starts cleanly and gives correct stats.
- CNT_W=4, two runs of 10 cycles -> total saturates at 15; min=10, max=10.

Source files
------------

// File: rtl/accel_drv_pkg.sv
// Shared types and helpers for the accelerator run driver.
// Holds the controller state encoding and the saturating adder used for the latency total.
package accel_drv_pkg;

    localparam int CNT_W_DEF = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Operands are zero-extended to 64 bits, so counters wider than 64 bits are not supported.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/accel_run_driver_sat_counter.sv
// Loadable up-counter that sticks at all ones instead of wrapping.
// Used for run latency and for timing the idle gap between runs.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/accel_run_driver.sv
// Launches the accelerator NUM_RUNS times back-to-back, timing each run and keeping
// last/min/max/total latency statistics, with an optional per-run hang timeout.
//
// Handshake: acc_start is a one-cycle pulse; the accelerator answers with acc_done, which is
// only looked at while a run is outstanding. stat_valid pulses in the cycle after the
// statistics registers have taken a new run's latency.
module accel_run_driver
    import accel_drv_pkg::*;
#(
    parameter int NUM_RUNS       = 4,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 2,
    parameter int RUN_W          = $clog2(NUM_RUNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             acc_done,
    output logic             acc_start,
    output logic             busy,
    output logic             all_done,
    output logic             timed_out,
    output logic [RUN_W-1:0] run_count,
    output logic             stat_valid,
    output logic [CNT_W-1:0] last_cycles,
    output logic [CNT_W-1:0] min_cycles,
    output logic [CNT_W-1:0] max_cycles,
    output logic [CNT_W-1:0] total_cycles
);

    localparam int               GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [63:0]      TIMEOUT_64 = 64'(TIMEOUT_CYCLES);
    localparam logic [RUN_W-1:0] LAST_RUN   = RUN_W'(NUM_RUNS - 1);
    localparam logic [GAP_W-1:0] GAP_END    = GAP_W'(GAP_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] lat;
    logic [GAP_W-1:0] gap_cnt;
    logic             lat_timeout;

    // Latency is 1 in the first WAIT cycle, so the START cycle itself is never counted.
    sat_counter #(.W(CNT_W)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state == START),
        .load_val (CNT_W'(1)),
        .inc      (state == WAIT),
        .count    (lat)
    );

    // Preloaded to 1 while waiting so the first GAP cycle already reads 1.
    sat_counter #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (state == WAIT),
        .load_val (GAP_W'(1)),
        .inc      (state == GAP),
        .count    (gap_cnt)
    );

    assign lat_timeout = (TIMEOUT_CYCLES != 0) && (64'(lat) == TIMEOUT_64);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc_start    <= 1'b0;
            busy         <= 1'b0;
            all_done     <= 1'b0;
            timed_out    <= 1'b0;
            stat_valid   <= 1'b0;
            run_count    <= '0;
            last_cycles  <= '0;
            min_cycles   <= '1;
            max_cycles   <= '0;
            total_cycles <= '0;
        end else begin
            acc_start  <= 1'b0;
            stat_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= START;
                        acc_start    <= 1'b1;
                        busy         <= 1'b1;
                        timed_out    <= 1'b0;
                        run_count    <= '0;
                        last_cycles  <= '0;
                        min_cycles   <= '1;
                        max_cycles   <= '0;
                        total_cycles <= '0;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // A done that lands on the timeout cycle still counts as a completed run.
                    if (acc_done) begin
                        last_cycles  <= lat;
                        total_cycles <= CNT_W'(sat_add(64'(total_cycles), 64'(lat), 64'(CNT_MAX)));
                        if (lat < min_cycles) min_cycles <= lat;
                        if (lat > max_cycles) max_cycles <= lat;
                        run_count  <= run_count + RUN_W'(1);
                        stat_valid <= 1'b1;
                        if (run_count == LAST_RUN) begin
                            state    <= FINISH;
                            busy     <= 1'b0;
                            all_done <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state     <= START;
                            acc_start <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else if (lat_timeout) begin
                        timed_out <= 1'b1;
                        state     <= FINISH;
                        busy      <= 1'b0;
                        all_done  <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state     <= START;
                        acc_start <= 1'b1;
                    end
                end
                FINISH: begin
                    if (!enable) begin
                        state    <= IDLE;
                        all_done <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    all_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_run_driver.sv
// Bench for accel_run_driver: a timeline model predicts every output each cycle for a
// 3-run configuration; a second small-counter instance is checked with literal values.
`timescale 1ns/1ps
module tb_accel_run_driver;

    localparam int NR   = 3;
    localparam int CW   = 16;
    localparam int TO   = 20;
    localparam int GP   = 2;
    localparam int RW   = $clog2(NR + 1);
    localparam int MAXV = (1 << CW) - 1;
    localparam int RWB  = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enable, acc_done;
    logic          acc_start, busy, all_done, timed_out, stat_valid;
    logic [RW-1:0] run_count;
    logic [CW-1:0] last_cycles, min_cycles, max_cycles, total_cycles;

    logic           enable_b, done_b;
    logic           start_b, busy_b, all_done_b, timed_out_b, sv_b;
    logic [RWB-1:0] run_count_b;
    logic [3:0]     last_b, min_b, max_b, total_b;

    accel_run_driver #(
        .NUM_RUNS(NR), .CNT_W(CW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .acc_done(acc_done),
        .acc_start(acc_start), .busy(busy), .all_done(all_done), .timed_out(timed_out),
        .run_count(run_count), .stat_valid(stat_valid), .last_cycles(last_cycles),
        .min_cycles(min_cycles), .max_cycles(max_cycles), .total_cycles(total_cycles)
    );

    accel_run_driver #(
        .NUM_RUNS(2), .CNT_W(4), .TIMEOUT_CYCLES(0), .GAP_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .acc_done(done_b),
        .acc_start(start_b), .busy(busy_b), .all_done(all_done_b), .timed_out(timed_out_b),
        .run_count(run_count_b), .stat_valid(sv_b), .last_cycles(last_b),
        .min_cycles(min_b), .max_cycles(max_b), .total_cycles(total_b)
    );

    typedef struct packed {
        logic          start;
        logic          busy;
        logic          all_done;
        logic          timed_out;
        logic          stat_valid;
        logic [RW-1:0] run_count;
        logic [CW-1:0] last;
        logic [CW-1:0] min;
        logic [CW-1:0] max;
        logic [CW-1:0] total;
    } exp_t;

    // scoreboard
    exp_t exp_q[$];
    exp_t idle_exp, reset_exp;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;

    // session timeline: cycle 0 is the IDLE cycle in which enable is first seen
    int s_c[NR], d_c[NR], lat_c[NR];
    int n_rec, n_started, to_c, end_c, f_c;

    function automatic void plan(input int lats[NR], input int d_en);
        int s;
        s = 1;
        n_rec = 0;
        n_started = 0;
        to_c = -1;
        end_c = 0;
        for (int i = 0; i < NR && to_c < 0; i++) begin
            s_c[i] = s;
            n_started++;
            if (lats[i] >= 1 && lats[i] <= TO) begin
                lat_c[i] = lats[i];
                d_c[i]   = s + lats[i];
                end_c    = d_c[i];
                n_rec++;
                s = d_c[i] + 1 + GP;
            end else begin
                to_c  = s + TO;
                end_c = to_c;
            end
        end
        f_c = (d_en > end_c + 1) ? d_en : end_c + 1;
    endfunction

    function automatic bit is_done(input int c);
        for (int i = 0; i < n_rec; i++) if (d_c[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_wait(input int c);
        for (int i = 0; i < n_started; i++) begin
            if (c > s_c[i] && c <= ((i < n_rec) ? d_c[i] : to_c)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic exp_t model_at(input int c);
        exp_t   e;
        int     rc, lastv, minv, maxv;
        longint tot;
        e = reset_exp;
        rc = 0; lastv = 0; minv = MAXV; maxv = 0; tot = 0;
        e.busy      = (c >= 1 && c <= end_c);
        e.all_done  = (c > end_c && c <= f_c);
        e.timed_out = (to_c >= 0 && c > to_c);
        for (int i = 0; i < n_started; i++) if (s_c[i] == c) e.start = 1'b1;
        for (int i = 0; i < n_rec; i++) begin
            if (d_c[i] < c) begin
                rc++;
                lastv = lat_c[i];
                if (lat_c[i] < minv) minv = lat_c[i];
                if (lat_c[i] > maxv) maxv = lat_c[i];
                tot += longint'(lat_c[i]);
            end
            if (d_c[i] + 1 == c) e.stat_valid = 1'b1;
        end
        e.run_count = RW'(rc);
        e.last      = CW'(lastv);
        e.min       = CW'(minv);
        e.max       = CW'(maxv);
        e.total     = (tot > longint'(MAXV)) ? CW'(MAXV) : CW'(tot);
        return e;
    endfunction

    // driver tasks
    task automatic run_session(input int lats[NR], input int d_en, input int noise, input int rst_at);
        int last_c;
        plan(lats, d_en);
        last_c = (rst_at > 0) ? rst_at + 1 : f_c + 1;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            enable = (c < d_en) && !(rst_at > 0 && c >= rst_at);
            rst    = (rst_at > 0 && c == rst_at);
            if (is_done(c))      acc_done = 1'b1;
            else if (is_wait(c)) acc_done = 1'b0;
            else if (noise == 2) acc_done = 1'b1;
            else if (noise == 1) acc_done = 1'($urandom_range(0, 1));
            else                 acc_done = 1'b0;
            if (c == 0)                             exp_q.push_back(idle_exp);
            else if (rst_at > 0 && c == rst_at + 1) exp_q.push_back(reset_exp);
            else                                    exp_q.push_back(model_at(c));
        end
        idle_exp = (rst_at > 0) ? reset_exp : model_at(last_c);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            acc_done = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // per-cycle compare of the main instance against the model
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else                  e = idle_exp;
                a = {acc_start, busy, all_done, timed_out, stat_valid, run_count,
                     last_cycles, min_cycles, max_cycles, total_cycles};
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_check t=%0t got st=%b bz=%b ad=%b to=%b sv=%b rc=%0d l=%0d mn=%0d mx=%0d tt=%0d expected st=%b bz=%b ad=%b to=%b sv=%b rc=%0d l=%0d mn=%0d mx=%0d tt=%0d",
                             $time, a.start, a.busy, a.all_done, a.timed_out, a.stat_valid, a.run_count,
                             a.last, a.min, a.max, a.total, e.start, e.busy, e.all_done, e.timed_out,
                             e.stat_valid, e.run_count, e.last, e.min, e.max, e.total);
                end
            end
        end
    end

    initial begin
        int l[NR];
        rst = 1'b1; enable = 1'b0; acc_done = 1'b0; enable_b = 1'b0; done_b = 1'b0;
        reset_exp = '0;
        reset_exp.min = '1;
        idle_exp = reset_exp;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_min", 64'(min_cycles), 64'(16'hFFFF));
        check("rst_busy", 64'(busy), 64'd0);
        check("b_rst_min", 64'(min_b), 64'd15);

        // three runs 5/9/7 with enable held well past completion
        l = '{5, 9, 7};
        run_session(l, 40, 1, 0);
        @(negedge clk);
        check("s1_last", 64'(last_cycles), 64'd7);
        check("s1_min", 64'(min_cycles), 64'd5);
        check("s1_max", 64'(max_cycles), 64'd9);
        check("s1_total", 64'(total_cycles), 64'd21);
        check("s1_runs", 64'(run_count), 64'd3);
        check("s1_model_total", 64'(idle_exp.total), 64'd21);

        // done held high through START: first run latency 1
        l = '{1, 3, 2};
        run_session(l, 2, 2, 0);
        @(negedge clk);
        check("s2_min", 64'(min_cycles), 64'd1);
        check("s2_last", 64'(last_cycles), 64'd2);

        // hung first run times out
        l = '{0, 0, 0};
        run_session(l, 5, 1, 0);
        @(negedge clk);
        check("s3_timed_out", 64'(timed_out), 64'd1);
        check("s3_runs", 64'(run_count), 64'd0);
        check("s3_min", 64'(min_cycles), 64'(16'hFFFF));

        // done on the timeout cycle wins
        l = '{20, 4, 4};
        run_session(l, 3, 1, 0);
        @(negedge clk);
        check("s4_timed_out", 64'(timed_out), 64'd0);
        check("s4_max", 64'(max_cycles), 64'd20);
        check("s4_total", 64'(total_cycles), 64'd28);

        // reset in the middle of run 2, then a clean session
        l = '{5, 9, 7};
        run_session(l, 30, 1, 12);
        @(negedge clk);
        check("s5_runs", 64'(run_count), 64'd0);
        check("s5_min", 64'(min_cycles), 64'(16'hFFFF));
        l = '{4, 6, 5};
        run_session(l, 3, 1, 0);
        @(negedge clk);
        check("s6_total", 64'(total_cycles), 64'd15);

        // randomized sessions; latencies above the timeout become hangs
        repeat (12) begin
            for (int i = 0; i < NR; i++) begin
                l[i] = $urandom_range(1, 22);
                if (l[i] > TO) l[i] = 0;
            end
            run_session(l, $urandom_range(1, 60), 1, 0);
            idle_cycles($urandom_range(0, 3));
        end

        // 4-bit counters, no gap, no timeout: two runs of 10
        for (int c = 0; c <= 26; c++) begin
            @(posedge clk); #1;
            enable_b = (c <= 24);
            done_b   = (c == 11 || c == 22);
            @(negedge clk);
            if (c == 1)  check("b_start1", 64'(start_b), 64'd1);
            if (c == 11) check("b_busy", 64'(busy_b), 64'd1);
            if (c == 12) begin
                check("b_start2", 64'(start_b), 64'd1);
                check("b_sv1", 64'(sv_b), 64'd1);
                check("b_total1", 64'(total_b), 64'd10);
            end
            if (c == 23) begin
                check("b_all_done", 64'(all_done_b), 64'd1);
                check("b_total_sat", 64'(total_b), 64'd15);
                check("b_min", 64'(min_b), 64'd10);
                check("b_max", 64'(max_b), 64'd10);
                check("b_runs", 64'(run_count_b), 64'd2);
                check("b_sv2", 64'(sv_b), 64'd1);
            end
            if (c == 25) check("b_hold", 64'(all_done_b), 64'd1);
            if (c == 26) check("b_exit", 64'(all_done_b), 64'd0);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
